// File: rtl/mcp3x0x_pkg.sv
// Shared types and constants for the MCP3x0x scanning controller.
package mcp3x0x_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_SHIFT,
    ST_CS_HOLD
  } state_t;

  localparam logic        START_BIT = 1'b1;
  localparam int unsigned CHN_W     = 3;

  // SPI clocks per frame: 5 command bits, sample period, null bit, data bits
  function automatic int unsigned frame_len(input int unsigned res_bits);
    return 7 + res_bits;
  endfunction

endpackage

// File: rtl/mcp3x0x_spi_frame.sv
// One MCP3x0x SPI transaction: CS setup, command/data shift, CS hold.
module mcp3x0x_spi_frame
  import mcp3x0x_pkg::*;
#(
  parameter int unsigned RES_BITS = 10
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                ena_i,
  input  logic                go_i,
  input  logic [CHN_W-1:0]    chn_i,
  input  logic                single_i,
  output logic                done_o,
  output logic                frame_end_o,
  output logic [RES_BITS-1:0] result_o,
  output logic                ad_ncs_o,
  output logic                ad_clk_o,
  output logic                ad_din_o,
  input  logic                ad_dout_i
);

  localparam int unsigned FRAME   = frame_len(RES_BITS);
  localparam logic [5:0]  H_LAST  = 6'(2 * FRAME - 1);
  localparam logic [4:0]  S_FIRST = 5'd7;
  localparam logic [4:0]  S_LAST  = 5'(6 + RES_BITS);

  state_t              state;
  logic [5:0]          half;
  logic                hold;
  logic [CHN_W-1:0]    chn_q;
  logic                single_q;
  logic [RES_BITS-1:0] sreg;

  // done fires on the last SHIFT tick so the result is registered by the
  // parent on the same edge that enters CS_HOLD.
  assign done_o      = (state == ST_SHIFT) && ena_i && (half == H_LAST);
  assign frame_end_o = (state == ST_CS_HOLD) && ena_i && hold;
  assign result_o    = sreg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= ST_IDLE;
      half     <= '0;
      hold     <= 1'b0;
      chn_q    <= '0;
      single_q <= 1'b0;
      sreg     <= '0;
      ad_ncs_o <= 1'b1;
      ad_clk_o <= 1'b0;
      ad_din_o <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (go_i) begin
            state    <= ST_CS_SETUP;
            ad_ncs_o <= 1'b0;
            chn_q    <= chn_i;
            single_q <= single_i;
          end
        end
        ST_CS_SETUP: begin
          if (ena_i) begin
            state    <= ST_SHIFT;
            half     <= '0;
            ad_din_o <= START_BIT;
          end
        end
        ST_SHIFT: begin
          if (ena_i) begin
            ad_clk_o <= ~ad_clk_o;
            half     <= half + 6'd1;
            // even half-bits are rising edges of clock half/2+1
            if (!half[0]) begin
              if (half[5:1] >= S_FIRST && half[5:1] <= S_LAST)
                sreg <= {sreg[RES_BITS-2:0], ad_dout_i};
            end else begin
              unique case (half[5:1])
                5'd0:    ad_din_o <= single_q;
                5'd1:    ad_din_o <= chn_q[2];
                5'd2:    ad_din_o <= chn_q[1];
                5'd3:    ad_din_o <= chn_q[0];
                default: ad_din_o <= 1'b0;
              endcase
            end
            if (half == H_LAST) begin
              state    <= ST_CS_HOLD;
              hold     <= 1'b0;
              ad_ncs_o <= 1'b1;
            end
          end
        end
        ST_CS_HOLD: begin
          if (ena_i) begin
            if (!hold) begin
              hold <= 1'b1;
            end else if (go_i) begin
              state    <= ST_CS_SETUP;
              ad_ncs_o <= 1'b0;
              chn_q    <= chn_i;
              single_q <= single_i;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/mcp3x0x_scanner.sv
// MCP3004/3008/3204/3208 controller: single conversions, channel scans, result bank.
module mcp3x0x_scanner
  import mcp3x0x_pkg::*;
#(
  parameter int unsigned RES_BITS   = 10,
  parameter int unsigned N_CHN      = 8,
  parameter bit          FULL_RESET = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic                scan_i,
  input  logic                cont_i,
  input  logic [CHN_W-1:0]    chn_i,
  input  logic                single_i,
  input  logic                ena_i,
  output logic                busy_o,
  output logic                eoc_o,
  output logic                eos_o,
  output logic [RES_BITS-1:0] data_o,
  output logic [CHN_W-1:0]    chn_o,
  input  logic [CHN_W-1:0]    rd_chn_i,
  output logic [RES_BITS-1:0] rd_data_o,
  output logic                ad_ncs_o,
  output logic                ad_clk_o,
  output logic                ad_din_o,
  input  logic                ad_dout_i
);

  localparam int unsigned      IDX_W    = (N_CHN > 4) ? 3 : 2;
  localparam logic [CHN_W:0]   N_CHN_L  = 4'(N_CHN);
  localparam logic [CHN_W-1:0] LAST_CHN = 3'(N_CHN - 1);

  logic                scan_q;
  logic                single_q;
  logic                more_q;
  logic [CHN_W-1:0]    cur_chn;
  logic                accept;
  logic                f_go;
  logic [CHN_W-1:0]    f_chn;
  logic                f_single;
  logic                f_done;
  logic                f_end;
  logic [RES_BITS-1:0] f_result;
  logic [RES_BITS-1:0] bank [N_CHN];

  assign accept   = !busy_o && start_i && (scan_i || ({1'b0, chn_i} < N_CHN_L));
  // A fresh request bypasses the latches so the frame starts on the accept edge.
  assign f_go     = accept || more_q;
  assign f_chn    = accept ? (scan_i ? '0 : chn_i) : cur_chn;
  assign f_single = accept ? single_i : single_q;

  mcp3x0x_spi_frame #(
    .RES_BITS(RES_BITS)
  ) u_frame (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .ena_i      (ena_i),
    .go_i       (f_go),
    .chn_i      (f_chn),
    .single_i   (f_single),
    .done_o     (f_done),
    .frame_end_o(f_end),
    .result_o   (f_result),
    .ad_ncs_o   (ad_ncs_o),
    .ad_clk_o   (ad_clk_o),
    .ad_din_o   (ad_din_o),
    .ad_dout_i  (ad_dout_i)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_o   <= 1'b0;
      eoc_o    <= 1'b0;
      eos_o    <= 1'b0;
      scan_q   <= 1'b0;
      single_q <= 1'b0;
      more_q   <= 1'b0;
      cur_chn  <= '0;
    end else begin
      eoc_o <= f_done;
      eos_o <= f_done && scan_q && (cur_chn == LAST_CHN);
      if (accept) begin
        busy_o   <= 1'b1;
        scan_q   <= scan_i;
        single_q <= single_i;
        cur_chn  <= scan_i ? '0 : chn_i;
        more_q   <= 1'b0;
      end
      // cont_i is only consulted when the last channel of a scan completes
      if (f_done) begin
        if (scan_q && ((cur_chn != LAST_CHN) || cont_i)) begin
          more_q  <= 1'b1;
          cur_chn <= (cur_chn == LAST_CHN) ? '0 : cur_chn + 3'd1;
        end else begin
          more_q <= 1'b0;
        end
      end
      if (f_end && !more_q)
        busy_o <= 1'b0;
    end
  end

  if (FULL_RESET) begin : g_full_rst
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        data_o <= '0;
        chn_o  <= '0;
        bank   <= '{default: '0};
      end else if (f_done) begin
        data_o                    <= f_result;
        chn_o                     <= cur_chn;
        bank[cur_chn[IDX_W-1:0]]  <= f_result;
      end
    end
  end else begin : g_no_data_rst
    always_ff @(posedge clk_i) begin
      if (f_done) begin
        data_o                    <= f_result;
        chn_o                     <= cur_chn;
        bank[cur_chn[IDX_W-1:0]]  <= f_result;
      end
    end
  end

  assign rd_data_o = ({1'b0, rd_chn_i} < N_CHN_L) ? bank[rd_chn_i[IDX_W-1:0]] : '0;

endmodule

// File: tb/tb_mcp3x0x_scanner.sv
// Scoreboard bench for mcp3x0x_scanner: 10-bit/8-channel and 12-bit/4-channel instances.
module tb_mcp3x0x_scanner;

  typedef struct {
    logic [11:0] data;
    logic [2:0]  chn;
    logic        eos;
    logic [4:0]  cmd;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   a_eoc_cnt = 0;
  int   b_eoc_cnt = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // instance A: RES_BITS=10, N_CHN=8, FULL_RESET=1, ena_i tied high
  logic       a_rst = 1'b1, a_start = 1'b0, a_scan = 1'b0, a_cont = 1'b0, a_single = 1'b0;
  logic [2:0] a_chn = '0, a_rd = '0;
  logic       a_busy, a_eoc, a_eos, a_ncs, a_sclk, a_din;
  logic       a_dout = 1'b0;
  logic [9:0] a_data, a_rdd;
  logic [2:0] a_chno;

  // instance B: RES_BITS=12, N_CHN=4, FULL_RESET=0, ena_i every third clock
  logic        b_rst = 1'b1, b_start = 1'b0, b_scan = 1'b0, b_cont = 1'b0, b_single = 1'b0;
  logic [2:0]  b_chn = '0, b_rd = '0;
  logic        b_ena = 1'b0;
  logic        b_busy, b_eoc, b_eos, b_ncs, b_sclk, b_din;
  logic        b_dout = 1'b0;
  logic [11:0] b_data, b_rdd;
  logic [2:0]  b_chno;

  mcp3x0x_scanner #(.RES_BITS(10), .N_CHN(8), .FULL_RESET(1'b1)) u_dut_a (
    .clk_i(clk), .rst_i(a_rst), .start_i(a_start), .scan_i(a_scan), .cont_i(a_cont),
    .chn_i(a_chn), .single_i(a_single), .ena_i(1'b1), .busy_o(a_busy), .eoc_o(a_eoc),
    .eos_o(a_eos), .data_o(a_data), .chn_o(a_chno), .rd_chn_i(a_rd), .rd_data_o(a_rdd),
    .ad_ncs_o(a_ncs), .ad_clk_o(a_sclk), .ad_din_o(a_din), .ad_dout_i(a_dout)
  );

  mcp3x0x_scanner #(.RES_BITS(12), .N_CHN(4), .FULL_RESET(1'b0)) u_dut_b (
    .clk_i(clk), .rst_i(b_rst), .start_i(b_start), .scan_i(b_scan), .cont_i(b_cont),
    .chn_i(b_chn), .single_i(b_single), .ena_i(b_ena), .busy_o(b_busy), .eoc_o(b_eoc),
    .eos_o(b_eos), .data_o(b_data), .chn_o(b_chno), .rd_chn_i(b_rd), .rd_data_o(b_rdd),
    .ad_ncs_o(b_ncs), .ad_clk_o(b_sclk), .ad_din_o(b_din), .ad_dout_i(b_dout)
  );

  int b_ph = 0;
  initial forever begin
    @(negedge clk);
    b_ph  = (b_ph == 2) ? 0 : b_ph + 1;
    b_ena = (b_ph == 0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
  endtask

  function automatic logic dbit(input int j, input logic [11:0] v, input int res);
    if (j >= 8 && j <= 7 + res) return v[res - 1 - (j - 8)];
    return 1'b0;
  endfunction

  // ADC slave models: decode the 5 command bits, drive data after falling SCK
  logic [11:0] a_base = '0, b_base = '0;
  logic        a_add = 1'b0, b_add = 1'b0;
  logic [4:0]  a_cmd = '0, b_cmd = '0;
  logic        a_prev = 1'b0, b_prev = 1'b0;
  int          a_k = 0, b_k = 0;

  always @(a_ncs or a_sclk) begin
    if (a_ncs !== 1'b0) begin
      a_k = 0; a_dout = 1'b0;
    end else if (a_sclk === 1'b1 && a_prev === 1'b0) begin
      a_k++;
      if (a_k <= 5) a_cmd = {a_cmd[3:0], a_din};
    end else if (a_sclk === 1'b0 && a_prev === 1'b1) begin
      a_dout = dbit(a_k + 1, a_base + (a_add ? 12'(a_cmd[2:0]) : 12'd0), 10);
    end
    a_prev = a_sclk;
  end

  always @(b_ncs or b_sclk) begin
    if (b_ncs !== 1'b0) begin
      b_k = 0; b_dout = 1'b0;
    end else if (b_sclk === 1'b1 && b_prev === 1'b0) begin
      b_k++;
      if (b_k <= 5) b_cmd = {b_cmd[3:0], b_din};
    end else if (b_sclk === 1'b0 && b_prev === 1'b1) begin
      b_dout = dbit(b_k + 1, b_base + (b_add ? 12'(b_cmd[2:0]) : 12'd0), 12);
    end
    b_prev = b_sclk;
  end

  // monitors: pop one expected result per eoc pulse
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (a_eoc === 1'b1) begin
      a_eoc_cnt++;
      if (qa.size() == 0) check("a_unexpected_eoc", 32'(a_eoc), 32'd0);
      else begin
        e = qa.pop_front();
        check("a_data", 32'(a_data), 32'(e.data));
        check("a_chn", 32'(a_chno), 32'(e.chn));
        check("a_eos", 32'(a_eos), 32'(e.eos));
        check("a_mosi_cmd", 32'(a_cmd), 32'(e.cmd));
        check("a_ncs_at_eoc", 32'(a_ncs), 32'd1);
      end
    end else if (a_eos === 1'b1) check("a_eos_without_eoc", 32'(a_eos), 32'd0);
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (b_eoc === 1'b1) begin
      b_eoc_cnt++;
      if (qb.size() == 0) check("b_unexpected_eoc", 32'(b_eoc), 32'd0);
      else begin
        e = qb.pop_front();
        check("b_data", 32'(b_data), 32'(e.data));
        check("b_chn", 32'(b_chno), 32'(e.chn));
        check("b_eos", 32'(b_eos), 32'(e.eos));
        check("b_mosi_cmd", 32'(b_cmd), 32'(e.cmd));
      end
    end else if (b_eos === 1'b1) check("b_eos_without_eoc", 32'(b_eos), 32'd0);
  end

  task automatic go_a(input logic scan, input logic cont, input logic [2:0] chn, input logic single);
    @(negedge clk);
    a_scan = scan; a_cont = cont; a_chn = chn; a_single = single; a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
  endtask

  task automatic go_b(input logic scan, input logic cont, input logic [2:0] chn, input logic single);
    @(negedge clk);
    b_scan = scan; b_cont = cont; b_chn = chn; b_single = single; b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
  endtask

  task automatic push_a(input logic [11:0] d, input logic [2:0] c, input logic eos, input logic sgl);
    exp_t e;
    e.data = d; e.chn = c; e.eos = eos; e.cmd = {1'b1, sgl, c};
    qa.push_back(e);
  endtask

  task automatic push_b(input logic [11:0] d, input logic [2:0] c, input logic eos, input logic sgl);
    exp_t e;
    e.data = d; e.chn = c; e.eos = eos; e.cmd = {1'b1, sgl, c};
    qb.push_back(e);
  endtask

  task automatic wait_idle_a(input int limit);
    int n = 0;
    while (a_busy && n < limit) begin @(negedge clk); n++; end
    check("a_idle_timeout", 32'(a_busy), 32'd0);
  endtask

  task automatic wait_idle_b(input int limit);
    int n = 0;
    while (b_busy && n < limit) begin @(negedge clk); n++; end
    check("b_idle_timeout", 32'(b_busy), 32'd0);
  endtask

  task automatic wait_a_eoc(output int t);
    int n = 0;
    @(negedge clk);
    while (a_eoc !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
    t = cyc;
  endtask

  task automatic wait_b_eoc(output int t);
    int n = 0;
    @(negedge clk);
    while (b_eoc !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
    t = cyc;
  endtask

  task automatic wait_b_sclk_rise(output int t);
    int   n = 0;
    logic prev = b_sclk;
    @(negedge clk);
    while (!(b_sclk === 1'b1 && prev === 1'b0) && n < 300) begin
      prev = b_sclk; @(negedge clk); n++;
    end
    t = cyc;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int t1, t2, n, cnt, snap;

    repeat (3) @(negedge clk);
    a_rst = 1'b0; b_rst = 1'b0;
    @(negedge clk);
    check("a_rst_busy", 32'(a_busy), 32'd0);
    check("a_rst_eoc", 32'(a_eoc), 32'd0);
    check("a_rst_ncs", 32'(a_ncs), 32'd1);
    check("a_rst_sclk", 32'(a_sclk), 32'd0);
    check("a_rst_din", 32'(a_din), 32'd0);
    check("a_rst_data", 32'(a_data), 32'd0);
    check("a_rst_chn", 32'(a_chno), 32'd0);
    a_rd = 3'd5; #1;
    check("a_rst_bank5", 32'(a_rdd), 32'd0);
    check("b_rst_busy", 32'(b_busy), 32'd0);
    check("b_rst_ncs", 32'(b_ncs), 32'd1);
    check("b_rst_eos", 32'(b_eos), 32'd0);

    // A: single conversion, channel 5, single-ended
    a_base = 12'h2A5; a_add = 1'b0;
    push_a(12'h2A5, 3'd5, 1'b0, 1'b1);
    go_a(1'b0, 1'b0, 3'd5, 1'b1);
    check("a_busy_after_start", 32'(a_busy), 32'd1);
    check("a_ncs_low_after_start", 32'(a_ncs), 32'd0);
    n = 0;
    while (a_eoc !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    check("a_ncs_fall_to_eoc", 32'(n), 32'd35);
    @(negedge clk);
    check("a_busy_in_hold", 32'(a_busy), 32'd1);
    @(negedge clk);
    check("a_busy_after_hold", 32'(a_busy), 32'd0);
    a_rd = 3'd5; #1;
    check("a_bank5", 32'(a_rdd), 32'h2A5);

    // A: continuous differential scan, cont dropped during the second pass
    a_base = 12'h200; a_add = 1'b1;
    for (int i = 0; i < 16; i++) push_a(12'h200 + 12'(i % 8), 3'(i % 8), (i % 8) == 7, 1'b0);
    go_a(1'b1, 1'b1, 3'd0, 1'b0);
    t1 = 0; t2 = 0; cnt = 0;
    for (int i = 0; i < 12; i++) begin
      wait_a_eoc(snap);
      if (a_eoc === 1'b1) cnt++;
      if (i == 0) t1 = snap;
      if (i == 1) t2 = snap;
    end
    a_cont = 1'b0;
    check("a_eoc_count_before_drop", 32'(cnt), 32'd12);
    check("a_eoc_spacing", 32'(t2 - t1), 32'd37);
    wait_idle_a(2000);
    for (int i = 0; i < 8; i++) begin
      a_rd = 3'(i); #1;
      check("a_bank_scan", 32'(a_rdd), 32'h200 + 32'(i));
    end
    @(negedge clk);
    check("a_eos_idle", 32'(a_eos), 32'd0);

    // A: reset asserted around half-bit 10 of a frame
    a_base = 12'h155; a_add = 1'b0;
    go_a(1'b0, 1'b0, 3'd3, 1'b1);
    cnt = 0; n = 0;
    while (cnt < 5 && n < 200) begin @(negedge clk); n++; if (a_sclk === 1'b1) cnt++; end
    @(negedge clk);
    check("a_ncs_before_reset", 32'(a_ncs), 32'd0);
    snap = a_eoc_cnt;
    #2 a_rst = 1'b1;
    #1;
    check("a_ncs_async_reset", 32'(a_ncs), 32'd1);
    check("a_sclk_async_reset", 32'(a_sclk), 32'd0);
    repeat (2) @(negedge clk);
    a_rst = 1'b0;
    @(negedge clk);
    check("a_busy_after_reset", 32'(a_busy), 32'd0);
    check("a_data_after_reset", 32'(a_data), 32'd0);
    a_rd = 3'd5; #1;
    check("a_bank5_after_reset", 32'(a_rdd), 32'd0);
    repeat (60) @(negedge clk);
    check("a_no_eoc_after_reset", 32'(a_eoc_cnt), 32'(snap));

    // B: 12-bit single conversion; a start while busy must be dropped
    b_base = 12'hABC; b_add = 1'b0;
    push_b(12'hABC, 3'd2, 1'b0, 1'b1);
    snap = b_eoc_cnt;
    go_b(1'b0, 1'b0, 3'd2, 1'b1);
    check("b_busy_after_start", 32'(b_busy), 32'd1);
    go_b(1'b1, 1'b0, 3'd0, 1'b1);
    wait_b_sclk_rise(t1);
    wait_b_sclk_rise(t2);
    check("b_sclk_period", 32'(t2 - t1), 32'd6);
    wait_idle_b(2000);
    repeat (20) @(negedge clk);
    check("b_one_frame_only", 32'(b_eoc_cnt - snap), 32'd1);
    check("b_data_12bit", 32'(b_data), 32'hABC);

    // B: out-of-range channel request is ignored
    go_b(1'b0, 1'b0, 3'd6, 1'b1);
    check("b_busy_bad_chn", 32'(b_busy), 32'd0);
    repeat (10) @(negedge clk);
    check("b_ncs_bad_chn", 32'(b_ncs), 32'd1);
    check("b_no_eoc_bad_chn", 32'(b_eoc_cnt - snap), 32'd1);

    // B: one-pass scan over 4 channels
    b_base = 12'h100; b_add = 1'b1;
    for (int i = 0; i < 4; i++) push_b(12'h100 + 12'(i), 3'(i), i == 3, 1'b1);
    go_b(1'b1, 1'b0, 3'd0, 1'b1);
    wait_b_eoc(t1);
    wait_b_eoc(t2);
    check("b_eoc_spacing", 32'(t2 - t1), 32'd123);
    wait_idle_b(2000);
    for (int i = 0; i < 4; i++) begin
      b_rd = 3'(i); #1;
      check("b_bank_scan", 32'(b_rdd), 32'h100 + 32'(i));
    end
    b_rd = 3'd6; #1;
    check("b_bank_out_of_range", 32'(b_rdd), 32'd0);
    check("b_last_chn", 32'(b_chno), 32'd3);

    repeat (5) @(negedge clk);
    check("a_queue_empty", 32'(qa.size()), 32'd0);
    check("b_queue_empty", 32'(qb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
